// File: rtl/fsm_div_sched_pkg.sv
// Shared types and constants for the fsm_div round-robin scheduler.
package fsm_div_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_SEND,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int unsigned N_OPS       = 4;
    localparam int unsigned SEND_CYCLES = 8;
    localparam int unsigned SEND_CNT_W  = $clog2(SEND_CYCLES);

    // Pointer/index width for n requesters (at least one bit).
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/fsm_div_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the pointer index has top priority, then ascending with wrap.
module fsm_div_sched_rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant_c,
    output logic [PW-1:0]    idx_c
);

    logic [PW-1:0] cand;
    logic          found;

    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = PW'((32'(ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found         = 1'b1;
                grant_c[cand] = 1'b1;
                idx_c         = cand;
            end
        end
    end

endmodule

// File: rtl/fsm_div_sched.sv
// Round-robin scheduler sharing one serial fsm_div unit between N_REQ requesters.
// Optional WAIT watchdog: define FSM_DIV_SCHED_TIMEOUT_EN.
module fsm_div_sched
    import fsm_div_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DW      = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] op_a,
    input  logic [N_REQ*DW-1:0] op_b,
    input  logic [N_REQ*DW-1:0] op_c,
    input  logic [N_REQ*DW-1:0] op_d,
    output logic [N_REQ-1:0]    ack,
    output logic [DW-1:0]       res_out,
    output logic                err_out,
    output logic                busy,
    output logic                div_reset,
    output logic                div_valid_in,
    output logic [DW-1:0]       div_d_in,
    input  logic                div_valid_out,
    input  logic [DW-1:0]       div_d_out,
    input  logic                div_error_out
`ifdef FSM_DIV_SCHED_TIMEOUT_EN
    ,
    output logic                timeout_out
`endif
);

    localparam int unsigned PW = ptr_w(N_REQ);
    localparam int unsigned CW = SEND_CNT_W;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("fsm_div_sched: parameter out of range");
    end

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [DW-1:0]     ops_q [N_OPS];
    logic [DW-1:0]     ops_d [N_OPS];
    logic [N_REQ-1:0]  arb_grant;
    logic [PW-1:0]     arb_idx;
    logic [N_REQ-1:0]  ack_d;
    logic [DW-1:0]     res_d;
    logic              err_d;
    logic              div_reset_d;
    logic              div_valid_d;
    logic [DW-1:0]     div_d_in_d;

`ifdef FSM_DIV_SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic              tmo_hit_q, tmo_hit_d;
    logic              timeout_d;
`endif

    fsm_div_sched_rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .grant_c (arb_grant),
        .idx_c   (arb_idx)
    );

    // Next-state and next-output logic; outputs are registered alongside the state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        ops_d       = ops_q;
        ack_d       = '0;
        res_d       = '0;
        err_d       = 1'b0;
        div_reset_d = 1'b0;
        div_valid_d = 1'b0;
        div_d_in_d  = div_d_in;
`ifdef FSM_DIV_SCHED_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        tmo_hit_d   = tmo_hit_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (|arb_grant) begin
                    state_d     = ST_SEND;
                    cnt_d       = '0;
                    win_d       = arb_idx;
                    ops_d[0]    = op_a[32'(arb_idx)*DW +: DW];
                    ops_d[1]    = op_b[32'(arb_idx)*DW +: DW];
                    ops_d[2]    = op_c[32'(arb_idx)*DW +: DW];
                    ops_d[3]    = op_d[32'(arb_idx)*DW +: DW];
                    div_valid_d = 1'b1;
                    div_d_in_d  = ops_d[0];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                // Even counts strobe the next operand, odd counts are the gap cycle.
                if (cnt_q == CW'(SEND_CYCLES - 1)) begin
                    state_d = ST_WAIT;
`ifdef FSM_DIV_SCHED_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end else begin
                    cnt_d       = cnt_q + CW'(1);
                    div_valid_d = ~cnt_d[0];
                    div_d_in_d  = ops_q[cnt_d[CW-1:1]];
                end
            end
            ST_WAIT: begin
`ifdef FSM_DIV_SCHED_TIMEOUT_EN
                if (tmo_hit_q) begin
                    state_d   = ST_RESP;
                    ack_d     = N_REQ'(1) << win_q;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                end else if (div_valid_out) begin
                    state_d = ST_RESP;
                    ack_d   = N_REQ'(1) << win_q;
                    res_d   = div_d_out;
                    err_d   = div_error_out;
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    tmo_hit_d   = 1'b1;
                    div_reset_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
`else
                if (div_valid_out) begin
                    state_d = ST_RESP;
                    ack_d   = N_REQ'(1) << win_q;
                    res_d   = div_d_out;
                    err_d   = div_error_out;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ptr_d   = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);
`ifdef FSM_DIV_SCHED_TIMEOUT_EN
                tmo_hit_d = 1'b0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ptr_q        <= '0;
            win_q        <= '0;
            for (int unsigned i = 0; i < N_OPS; i++) ops_q[i] <= '0;
            ack          <= '0;
            res_out      <= '0;
            err_out      <= 1'b0;
            busy         <= 1'b0;
            div_reset    <= 1'b1;
            div_valid_in <= 1'b0;
            div_d_in     <= '0;
`ifdef FSM_DIV_SCHED_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            tmo_hit_q    <= 1'b0;
            timeout_out  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            win_q        <= win_d;
            ops_q        <= ops_d;
            ack          <= ack_d;
            res_out      <= res_d;
            err_out      <= err_d;
            busy         <= (state_d != ST_IDLE);
            div_reset    <= div_reset_d;
            div_valid_in <= div_valid_d;
            div_d_in     <= div_d_in_d;
`ifdef FSM_DIV_SCHED_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            tmo_hit_q    <= tmo_hit_d;
            timeout_out  <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_fsm_div_sched.sv
// Scoreboard bench for fsm_div_sched with a behavioural fsm_div stub (a/b-c-d, error on a==0 or b==0).
module tb_fsm_div_sched;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned DW      = 4;
    localparam int unsigned TIMEOUT = 64;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [N_REQ-1:0]    req = '0;
    logic [N_REQ*DW-1:0] op_a = '0, op_b = '0, op_c = '0, op_d = '0;
    logic [N_REQ-1:0]    ack;
    logic [DW-1:0]       res_out;
    logic                err_out, busy, div_reset, div_valid_in;
    logic [DW-1:0]       div_d_in;
    logic                div_valid_out = 1'b0;
    logic [DW-1:0]       div_d_out = '0;
    logic                div_error_out = 1'b0;
`ifdef FSM_DIV_SCHED_TIMEOUT_EN
    logic                timeout_out;
`endif

    always #5 clk = ~clk;

    fsm_div_sched #(.N_REQ(N_REQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .op_a          (op_a),
        .op_b          (op_b),
        .op_c          (op_c),
        .op_d          (op_d),
        .ack           (ack),
        .res_out       (res_out),
        .err_out       (err_out),
        .busy          (busy),
        .div_reset     (div_reset),
        .div_valid_in  (div_valid_in),
        .div_d_in      (div_d_in),
        .div_valid_out (div_valid_out),
        .div_d_out     (div_d_out),
        .div_error_out (div_error_out)
`ifdef FSM_DIV_SCHED_TIMEOUT_EN
        ,
        .timeout_out   (timeout_out)
`endif
    );

    typedef struct {
        int idx;
        int res;
        int err;
        int tmo;
        int dr;
        int t0;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // fsm_div stub: collects four strobed operands, answers stub_lat cycles after the last one.
    int            stub_lat = 2;
    logic          stub_mute = 1'b0;
    logic          spur = 1'b0;
    int            n_in = 0;
    int            cd = 0;
    logic [DW-1:0] opv [4];

    always @(posedge clk) begin
        if (div_reset) begin
            n_in          <= 0;
            cd            <= 0;
            div_valid_out <= 1'b0;
        end else begin
            div_valid_out <= 1'b0;
            if (spur) begin
                div_valid_out <= 1'b1;
                div_d_out     <= 4'h7;
                div_error_out <= 1'b1;
            end
            if (div_valid_in) begin
                opv[n_in] <= div_d_in;
                n_in      <= (n_in == 3) ? 0 : n_in + 1;
                if (n_in == 3) cd <= stub_lat;
            end
            if (cd != 0) begin
                cd <= cd - 1;
                if (cd == 1 && !stub_mute) begin
                    div_valid_out <= 1'b1;
                    if (opv[0] == '0 || opv[1] == '0) begin
                        div_d_out     <= '0;
                        div_error_out <= 1'b1;
                    end else begin
                        div_d_out     <= DW'(opv[0] / opv[1] - opv[2] - opv[3]);
                        div_error_out <= 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: operand strobe spacing, watchdog resets, and ack/result against the scoreboard.
    int   pulses = 0;
    int   gap = 0;
    int   dr = 0;
    logic rst_prev = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        if (!reset) begin
            pulses = 0;
            gap    = 0;
            dr     = 0;
        end else begin
            if (rst_prev && div_reset) dr++;
            gap++;
            if (div_valid_in) begin
                if (pulses > 0) check("valid_in_spacing", gap, 2);
                pulses++;
                gap = 0;
            end
            if (ack != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", int'(ack), 0);
                end else begin
                    e = sb.pop_front();
                    check("ack_onehot", int'(ack), 1 << e.idx);
                    check("res_out", int'(res_out), e.res);
                    check("err_out", int'(err_out), e.err);
                    check("valid_in_pulses", pulses, 4);
                    check("div_reset_pulses", dr, e.dr);
`ifdef FSM_DIV_SCHED_TIMEOUT_EN
                    check("timeout_out", int'(timeout_out), e.tmo);
`endif
                    if (e.lat >= 0) check("ack_latency", cyc - e.t0, e.lat);
                end
                pulses = 0;
                dr     = 0;
            end
        end
        rst_prev = reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [DW-1:0] a, b, c, d);
        op_a[i*DW +: DW] = a;
        op_b[i*DW +: DW] = b;
        op_c[i*DW +: DW] = c;
        op_d[i*DW +: DW] = d;
    endtask

    task automatic expect_tx(input int idx, input int res, input int err, input int tmo,
                             input int drp, input int lat);
        exp_t x;
        x.idx = idx; x.res = res; x.err = err; x.tmo = tmo; x.dr = drp; x.t0 = cyc; x.lat = lat;
        sb.push_back(x);
    endtask

    // Raise req=mask, drop each bit as its ack is seen, wait for n acks within budget cycles.
    task automatic run(input logic [N_REQ-1:0] mask, input int n, input int budget);
        int got;
        got = 0;
        req = mask;
        for (int k = 0; k < budget && got < n; k++) begin
            @(negedge clk);
            if (ack != '0) begin
                got++;
                req = req & ~ack;
            end
        end
        check("ack_count", got, n);
        req = '0;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, int'(ack), 0);
        check({tag, "_res_out"}, int'(res_out), 0);
        check({tag, "_err_out"}, int'(err_out), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_div_reset"}, int'(div_reset), 1);
        check({tag, "_div_valid_in"}, int'(div_valid_in), 0);
        check({tag, "_div_d_in"}, int'(div_d_in), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int acks;
        repeat (3) tick();
        check_reset_outputs("por");
        reset = 1'b1;
        tick();
        check("idle_div_reset", int'(div_reset), 0);

        // T1: 8/2-5-2 = -3, W=3 gives 13 cycles req->ack
        set_ops(0, 4'd8, 4'd2, 4'd5, 4'd2);
        stub_lat = 3;
        expect_tx(0, 13, 0, 0, 0, 13);
        run(4'b0001, 1, 100);

        // T2: 9/2-1-3 = 0, W=1 gives 11 cycles
        set_ops(1, 4'd9, 4'd2, 4'd1, 4'd3);
        stub_lat = 1;
        expect_tx(1, 0, 0, 0, 0, 11);
        run(4'b0010, 1, 100);

        // T3: divide-by-zero and zero dividend both flag an error
        stub_lat = 2;
        set_ops(2, 4'd5, 4'd0, 4'd1, 4'd2);
        expect_tx(2, 0, 1, 0, 0, 12);
        run(4'b0100, 1, 100);
        set_ops(2, 4'd0, 4'd4, 4'd1, 4'd2);
        expect_tx(2, 0, 1, 0, 0, -1);
        run(4'b0100, 1, 100);

        // Pointer now at 3: simultaneous 3 and 0 are served 3 then 0
        set_ops(3, 4'd12, 4'd4, 4'd0, 4'd1);
        set_ops(0, 4'd8, 4'd2, 4'd5, 4'd2);
        expect_tx(3, 2, 0, 0, 0, -1);
        expect_tx(0, 13, 0, 0, 0, -1);
        run(4'b1001, 2, 200);

        // Stray result strobe while idle must not produce an ack
        spur = 1'b1;
        tick();
        spur = 1'b0;
        repeat (5) tick();
        check("stray_valid_out_busy", int'(busy), 0);

        // T4: all four at once after reset, then 0 and 3
        do_reset();
        set_ops(1, 4'd9, 4'd2, 4'd1, 4'd3);
        set_ops(2, 4'd7, 4'd3, 4'd1, 4'd0);
        expect_tx(0, 13, 0, 0, 0, -1);
        expect_tx(1, 0, 0, 0, 0, -1);
        expect_tx(2, 1, 0, 0, 0, -1);
        expect_tx(3, 2, 0, 0, 0, -1);
        run(4'b1111, 4, 400);
        expect_tx(0, 13, 0, 0, 0, -1);
        expect_tx(3, 2, 0, 0, 0, -1);
        run(4'b1001, 2, 200);

        // T5: reset during the third SEND cycle aborts client 1 without an ack
        req = 4'b0010;
        repeat (4) tick();
        check("send3_valid_in", int'(div_valid_in), 1);
        check("send3_d_in", int'(div_d_in), 2);
        reset = 1'b0;
        req   = '0;
        tick();
        tick();
        check_reset_outputs("abort");
        reset = 1'b1;
        acks = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack != '0) acks++;
        end
        check("abort_no_ack", acks, 0);
        tick();
        set_ops(2, 4'd8, 4'd2, 4'd5, 4'd2);
        expect_tx(2, 13, 0, 0, 0, 12);
        run(4'b0100, 1, 100);

`ifdef FSM_DIV_SCHED_TIMEOUT_EN
        // T6: silent divider -> watchdog reset pulse, then error ack with timeout_out
        stub_mute = 1'b1;
        expect_tx(0, 0, 1, 1, 1, TIMEOUT + 11);
        run(4'b0001, 1, TIMEOUT + 60);
        stub_mute = 1'b0;
`endif

        repeat (3) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
